// File: rtl/lc3_keyboard_reg_if.sv
// Bus bundle for the LC3 keyboard register block.
// It carries the character source handshake and the CPU memory-mapped I/O signals.
interface lc3_keyboard_reg_if;
  logic        KB_VALID;
  logic [7:0]  KB_CHAR;
  logic        KB_READY;
  logic        RD_KBDR;
  logic        LD_KBSR;
  logic [15:0] DATA;
  logic [15:0] KBSR;
  logic [15:0] KBDR;
  logic        KB_INT;

  // Driver side: the keyboard source and the CPU I/O decode.
  modport master (
    output KB_VALID, KB_CHAR, RD_KBDR, LD_KBSR, DATA,
    input  KB_READY, KBSR, KBDR, KB_INT
  );

  // Register block side.
  modport slave (
    input  KB_VALID, KB_CHAR, RD_KBDR, LD_KBSR, DATA,
    output KB_READY, KBSR, KBDR, KB_INT
  );
endinterface

// File: rtl/lc3_keyboard_reg.sv
// LC3 keyboard registers KBSR/KBDR.
// A character FIFO feeds a single presentation stage (KBDR plus valid bit KBSR[15]).
// A CPU read of KBDR pops the stage, and the stage refills from the FIFO on the same edge.
// Optional macro LC3_KBD_INT_EN enables the writable interrupt-enable bit KBSR[14] and KB_INT.
module lc3_keyboard_reg #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input logic               clk,
  input logic               rst_n,
  lc3_keyboard_reg_if.slave bus
);

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              stage_valid_q;
  logic [7:0]        stage_char_q;
  logic              int_en;
  logic              push, load;

  // The handshake uses the registered count, so a full FIFO never accepts a character.
  always_comb begin
    bus.KB_READY = (count_q != (ADDR_W + 1)'(FIFO_DEPTH));
    push         = bus.KB_VALID && bus.KB_READY;
    load         = (count_q != '0) && (!stage_valid_q || bus.RD_KBDR);
  end

  // Net FIFO occupancy change: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The storage array is not reset; the pointer reset discards its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.KB_CHAR;
  end

  // Pointers, count and the presentation stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_char_q  <= 8'h00;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        stage_char_q  <= fifo_mem[rd_ptr_q];
        stage_valid_q <= 1'b1;
        rd_ptr_q      <= rd_ptr_q + 1'b1;
      end else if (bus.RD_KBDR && stage_valid_q) begin
        // KBDR keeps its last value once it has been consumed.
        stage_valid_q <= 1'b0;
      end
    end
  end

`ifdef LC3_KBD_INT_EN
  logic int_en_q;

  // The interrupt enable is the only CPU-writable KBSR bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_en_q <= 1'b0;
    end else if (bus.LD_KBSR) begin
      int_en_q <= bus.DATA[14];
    end
  end

  logic unused_data;
  assign unused_data = ^{bus.DATA[15], bus.DATA[13:0]};
  assign int_en      = int_en_q;
`else
  logic unused_ld;
  assign unused_ld = ^{bus.LD_KBSR, bus.DATA};
  assign int_en    = 1'b0;
`endif

  // The register views and the interrupt are decoded straight from state, with no extra latency.
  always_comb begin
    bus.KBSR   = {stage_valid_q, int_en, 14'h0000};
    bus.KBDR   = {8'h00, stage_char_q};
    bus.KB_INT = stage_valid_q && int_en;
  end

endmodule
